// File: rtl/reg14_reader.sv
// First-word-fall-through circular buffer with registered read data and an occupancy count.
// Define REG14_READER_OVF_EN to build the sticky overflow flag for dropped writes.
module reg14_reader #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 14
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [W-1:0]             a,
   input  logic                     enable,
   output logic [W-1:0]             o,
   output logic                     ovalid,
   input  logic                     oready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  o_q, o_d;
   logic          push, pop;

   assign ovalid = (count_q != '0);
   assign full   = (count_q == CW'(DEPTH));
   assign count  = count_q;
   assign o      = o_q;

   always_comb begin
      pop     = ovalid && oready;
      push    = enable && (!full || pop);
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      o_d     = o_q;
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // New head is the word being written only when it lands where rp will point
      if (count_d != '0)
         o_d = (push && (wp_q == rp_d)) ? a : mem_q[rp_d];
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         o_q     <= W'(1);
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         o_q     <= o_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) mem_q[wp_q] <= a;
   end

`ifdef REG14_READER_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q | (enable && full && !pop);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) ovf_q <= 1'b0;
      else      ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_reg14_reader.sv
// Bench for reg14_reader: directed vector table, hand sequences and random traffic
// against a queue-based reference model.
module tb_reg14_reader;

   localparam int DEPTH = 4;

   logic        Clk;
   logic        Rst;
   logic [13:0] a;
   logic        enable;
   logic [13:0] o;
   logic        ovalid;
   logic        oready;
   logic [2:0]  count;
   logic        full;
   logic        ovf;

   reg14_reader #(.DEPTH(4), .W(14)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .a      (a),
      .enable (enable),
      .o      (o),
      .ovalid (ovalid),
      .oready (oready),
      .count  (count),
      .full   (full),
      .ovf    (ovf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int errs   = 0;
   int checks = 0;

   logic [13:0] q[$];
   logic [13:0] exp_o;
   logic        ovf_m;

   typedef struct {
      logic        en;
      logic [13:0] d;
      logic        rdy;
      int          ecount;
      logic        evalid;
      logic [13:0] eo;
      logic        efull;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO queue; pop only when non-empty, push when not full or popping.
   task automatic step(input logic en, input logic [13:0] d, input logic rdy);
      logic p_pop, p_full, p_push;
      @(negedge Clk);
      enable = en;
      a      = d;
      oready = rdy;
      @(posedge Clk);
      p_pop  = (q.size() != 0) && rdy;
      p_full = (q.size() == DEPTH);
      p_push = en && (!p_full || p_pop);
`ifdef REG14_READER_OVF_EN
      if (en && p_full && !p_pop) ovf_m = 1'b1;
`endif
      if (p_pop)  void'(q.pop_front());
      if (p_push) q.push_back(d);
      if (q.size() != 0) exp_o = q[0];
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_count"},  32'(count),  32'(q.size()));
      chk({tag, "_ovalid"}, 32'(ovalid), 32'(q.size() != 0));
      chk({tag, "_full"},   32'(full),   32'(q.size() == DEPTH));
      chk({tag, "_o"},      32'(o),      32'(exp_o));
      chk({tag, "_ovf"},    32'(ovf),    32'(ovf_m));
   endtask

   // Assert reset between edges and confirm outputs clear before any clock edge.
   task automatic do_reset(input string tag);
      @(negedge Clk);
      #2;
      Rst    = 1'b0;
      enable = 1'b0;
      oready = 1'b0;
      #1;
      q.delete();
      exp_o = 14'd1;
      ovf_m = 1'b0;
      chk({tag, "_rst_count"},  32'(count),  32'd0);
      chk({tag, "_rst_ovalid"}, 32'(ovalid), 32'd0);
      chk({tag, "_rst_o"},      32'(o),      32'd1);
      chk({tag, "_rst_full"},   32'(full),   32'd0);
      chk({tag, "_rst_ovf"},    32'(ovf),    32'd0);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   initial begin
      Rst    = 1'b1;
      enable = 1'b0;
      oready = 1'b0;
      a      = '0;
      exp_o  = 14'd1;
      ovf_m  = 1'b0;

      vt[0] = '{1'b1, 14'h0001, 1'b0, 1, 1'b1, 14'h0001, 1'b0};
      vt[1] = '{1'b1, 14'h1FFF, 1'b0, 2, 1'b1, 14'h0001, 1'b0};
      vt[2] = '{1'b1, 14'h2AAA, 1'b0, 3, 1'b1, 14'h0001, 1'b0};
      vt[3] = '{1'b1, 14'h3FFF, 1'b0, 4, 1'b1, 14'h0001, 1'b1};
      vt[4] = '{1'b0, 14'h0000, 1'b1, 3, 1'b1, 14'h1FFF, 1'b0};
      vt[5] = '{1'b0, 14'h0000, 1'b1, 2, 1'b1, 14'h2AAA, 1'b0};
      vt[6] = '{1'b0, 14'h0000, 1'b1, 1, 1'b1, 14'h3FFF, 1'b0};
      vt[7] = '{1'b0, 14'h0000, 1'b1, 0, 1'b0, 14'h3FFF, 1'b0};
      vt[8] = '{1'b0, 14'h0000, 1'b1, 0, 1'b0, 14'h3FFF, 1'b0};

      do_reset("init");

      // Ordering, full flag and empty-read behaviour
      for (int i = 0; i < 9; i++) begin
         step(vt[i].en, vt[i].d, vt[i].rdy);
         chk($sformatf("vec%0d_count", i),  32'(count),  32'(vt[i].ecount));
         chk($sformatf("vec%0d_ovalid", i), 32'(ovalid), 32'(vt[i].evalid));
         chk($sformatf("vec%0d_o", i),      32'(o),      32'(vt[i].eo));
         chk($sformatf("vec%0d_full", i),   32'(full),   32'(vt[i].efull));
         chk($sformatf("vec%0d_ovf", i),    32'(ovf),    32'd0);
      end

      // Dropped write while full
      do_reset("ovf");
      for (int i = 0; i < 4; i++) step(1'b1, 14'(16'h0100 + i), 1'b0);
      step(1'b1, 14'h1234, 1'b0);
      chk("ovf_count", 32'(count), 32'd4);
`ifdef REG14_READER_OVF_EN
      chk("ovf_flag", 32'(ovf), 32'd1);
`else
      chk("ovf_flag", 32'(ovf), 32'd0);
`endif
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 14'h0, 1'b1);
         check_model("ovf_drain");
         if (ovalid) chk("ovf_not_1234", 32'(o == 14'h1234), 32'd0);
      end

      // Simultaneous read and write while full
      do_reset("fullrw");
      for (int i = 0; i < 4; i++) step(1'b1, 14'(16'h0200 + i), 1'b0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 14'h0555, 1'b1);
         chk("fullrw_count", 32'(count), 32'd4);
         chk("fullrw_ovf",   32'(ovf),   32'd0);
         chk("fullrw_o",     32'(o),     (i < 3) ? 32'(16'h0201 + i) : 32'h0555);
      end

      // Pointer wrap with one entry in flight
      do_reset("wrap");
      step(1'b1, 14'd0, 1'b0);
      chk("wrap_o0", 32'(o), 32'd0);
      for (int i = 1; i < 10; i++) begin
         step(1'b1, 14'(i), 1'b1);
         chk($sformatf("wrap_o%0d", i), 32'(o), 32'(i));
         chk("wrap_count", 32'(count), 32'd1);
      end
      step(1'b0, 14'd0, 1'b1);
      check_model("wrap_end");

      // Reset in the middle of a stream
      for (int i = 0; i < 3; i++) step(1'b1, 14'(16'h0300 + i), 1'b0);
      chk("mid_count3", 32'(count), 32'd3);
      do_reset("mid");
      step(1'b1, 14'h0042, 1'b0);
      chk("mid_o",      32'(o),      32'h0042);
      chk("mid_ovalid", 32'(ovalid), 32'd1);

      // Random traffic against the model
      do_reset("rand");
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 60), 14'($urandom), ($urandom_range(0, 99) < 45));
         check_model("rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/reg14_reader.md
REG14_READER -- requirements
Module: reg14_reader

Interface
REQ-001 Parameter DEPTH, default 4, number of 14-bit entries; power of two, 2..16.
REQ-002 Parameter W, default 14, data width.
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  asynchronous, active-low reset; Rst=0 resets immediately, independent of Clk.
REQ-005 a  input  W  write data from the producing register stage.
REQ-006 enable  input  1  write strobe; a is captured on the posedge where enable=1.
REQ-007 o  output  W  read data; valid only while ovalid=1.
REQ-008 ovalid  output  1  an entry is present at o.
REQ-009 oready  input  1  consumer accepts o this cycle.
REQ-010 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-011 full  output  1  count==DEPTH.
REQ-012 ovf  output  1  sticky overflow flag (see REQ-029).

Function
REQ-013 Circular buffer of DEPTH entries; write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-014 Push = enable && (!full || pop); pop = ovalid && oready.
REQ-015 On push, a is stored at wp and wp increments.
REQ-016 On pop, rp increments and the next entry, if any, appears at o on the following cycle.
REQ-017 o and ovalid are registered outputs with first-word-fall-through behaviour; o always equals the entry at rp.
REQ-018 Latency: a push into an empty buffer at edge N gives ovalid=1 and o=a after edge N; there is no combinational path from a to o.
REQ-019 count changes as follows: push only, +1; pop only, -1; push and pop together, unchanged.
REQ-020 Simultaneous push and pop while full is legal; the data is accepted, count stays DEPTH, and ovf does not set.
REQ-021 Simultaneous push and pop with count==1 gives ovalid=1 on the next cycle, with o equal to the newly pushed a.
REQ-022 enable while full with no pop drops a; pointers and count are unchanged.
REQ-023 oready while empty has no effect; ovalid stays 0.
REQ-024 When empty, o holds its last value; after reset it holds 1.
REQ-025 ovalid = (count != 0); full = (count == DEPTH); both are derived from registered count.
REQ-026 Stored data is not altered by oready or by pointer wrap; order is strictly FIFO.

Reset
REQ-027 Rst=0 asynchronously sets wp=0, rp=0, count=0, ovalid=0, full=0, ovf=0, and o=1 (W'd1).
REQ-028 Reset during a transfer discards all entries; the first push after Rst rises behaves as push-into-empty (REQ-018).

Configuration
REQ-029 With macro REG14_READER_OVF_EN defined, ovf sets on the edge of any dropped write (REQ-022) and stays 1 until Rst=0.
REQ-030 Without REG14_READER_OVF_EN, ovf is tied to 0 and no overflow logic is built; all other behaviour is identical.

Verification
REQ-031 Reset/idle: Rst=0 mid-cycle -> o=1, ovalid=0, count=0 immediately, before the next Clk edge.
REQ-032 Order: push 14'h0001, 14'h1FFF, 14'h2AAA, 14'h3FFF with oready=0, then oready=1 -> o sequence 0001, 1FFF, 2AAA, 3FFF; full=1 after the 4th push; count returns to 0.
REQ-033 Overflow (OVF_EN defined): fill to 4 entries, push 14'h1234 with oready=0 -> count=4, ovf=1, 14'h1234 never appears at o; with OVF_EN undefined -> ovf=0.
REQ-034 Full plus simultaneous read/write: count=4, enable=1 with a=14'h0555 and oready=1 for 6 cycles -> count stays 4, ovf=0, and 14'h0555 appears in order after the original entries.
REQ-035 Wrap: 10 push/pop pairs of 14'd0..14'd9 at count==1 -> each value is output exactly once, in order, 1 cycle after its push; wp and rp wrap with no loss.
REQ-036 Reset mid-stream: with count=3, pulse Rst=0 -> count=0, o=1; the next push of 14'h0042 gives o=0042 and ovalid=1 one edge later.
